sev_seg_scan: RTL

SEV_SEG_SCAN -- requirements
Module: sev_seg_scan

---
 rtl/sev_seg_scan_pkg.sv | 13 +
 rtl/sev_seg_scan_decode.sv | 11 +
 rtl/sev_seg_scan.sv | 133 +++++++++++++
 3 files changed

// File: rtl/sev_seg_scan_pkg.sv
// Shared constants for the seven-segment scanner: segment codes, blank pattern, DP bit.
package sev_seg_scan_pkg;

  // {a,b,c,d,e,f,g,dp}, active low
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam int         DP_BIT    = 0;

  localparam logic [7:0] SEG_CODES [16] = '{
    8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
    8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71
  };

endpackage

// File: rtl/sev_seg_scan_decode.sv
// Hex nibble to active-low segment pattern; purely combinational.
module seg_decode
  import sev_seg_scan_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] seg
);

  assign seg = SEG_CODES[nibble];

endmodule

// File: rtl/sev_seg_scan.sv
// Multiplexed seven-segment scanner with double-buffered digit data, per-slot dead time,
// optional leading-zero blanking and a frame-start pulse; all outputs registered.
module sev_seg_scan
  import sev_seg_scan_pkg::*;
#(
  parameter int NUM_DIGITS       = 4,
  parameter int REFRESH_DIV      = 50000,
  parameter int BLANK_CYCLES     = 8,
  parameter int ANODE_ACTIVE_LOW = 1,
  parameter int LZ_BLANK         = 0
) (
  input  logic                      Clk,
  input  logic                      nReset,
  input  logic [4*NUM_DIGITS-1:0]   Data,
  input  logic [NUM_DIGITS-1:0]     DpIn,
  input  logic [NUM_DIGITS-1:0]     DigitEn,
  input  logic                      Load,
  output logic [7:0]                Segments,
  output logic [NUM_DIGITS-1:0]     Anodes,
  output logic                      FrameStart
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DW = 4 * NUM_DIGITS;

  localparam logic [PW-1:0]         PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0]         IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF     = {NUM_DIGITS{ANODE_ACTIVE_LOW != 0}};

  logic [PW-1:0]         presc;
  logic [IW-1:0]         idx;
  logic                  pending;
  logic [DW-1:0]         sh_data,  act_data;
  logic [NUM_DIGITS-1:0] sh_dp,    act_dp;
  // Digit enables are stored inverted so the all-zero reset state shows every digit.
  logic [NUM_DIGITS-1:0] sh_blank, act_blank;

  logic                  tc;
  logic                  wrap;

  assign tc   = (presc == PRESC_LAST);
  assign wrap = tc && (idx == IDX_LAST);

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      presc     <= '0;
      idx       <= '0;
      pending   <= 1'b0;
      sh_data   <= '0;
      sh_dp     <= '0;
      sh_blank  <= '0;
      act_data  <= '0;
      act_dp    <= '0;
      act_blank <= '0;
    end else begin
      presc <= tc ? '0 : presc + 1'b1;
      if (tc) idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;

      if (Load) begin
        sh_data  <= Data;
        sh_dp    <= DpIn;
        sh_blank <= ~DigitEn;
      end

      // A Load in the wrap cycle bypasses the shadow so it lands in this frame.
      if (wrap) begin
        pending <= 1'b0;
        if (Load) begin
          act_data  <= Data;
          act_dp    <= DpIn;
          act_blank <= ~DigitEn;
        end else if (pending) begin
          act_data  <= sh_data;
          act_dp    <= sh_dp;
          act_blank <= sh_blank;
        end
      end else if (Load) begin
        pending <= 1'b1;
      end
    end
  end

  logic [NUM_DIGITS-1:0] lz_mask;
  logic                  above_zero;
  logic                  nib_zero;

  always_comb begin
    lz_mask    = '0;
    above_zero = 1'b1;
    nib_zero   = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      nib_zero   = (act_data[4*i +: 4] == 4'd0);
      lz_mask[i] = above_zero && nib_zero && (i != 0) && !act_dp[i];
      above_zero = above_zero && nib_zero;
    end
  end

  logic [3:0]            cur_nib;
  logic [7:0]            dec_seg;
  logic [7:0]            seg_val;
  logic                  show;
  logic [NUM_DIGITS-1:0] sel;

  assign cur_nib = act_data[4*idx +: 4];

  seg_decode u_decode (
    .nibble (cur_nib),
    .seg    (dec_seg)
  );

  always_comb begin
    seg_val         = dec_seg;
    seg_val[DP_BIT] = dec_seg[DP_BIT] & ~act_dp[idx];
  end

  assign show = (int'(presc) >= BLANK_CYCLES) && !act_blank[idx]
                && !((LZ_BLANK != 0) && lz_mask[idx]);
  assign sel  = NUM_DIGITS'(1) << idx;

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      Segments   <= SEG_BLANK;
      Anodes     <= AN_OFF;
      FrameStart <= 1'b0;
    end else begin
      Segments   <= show ? seg_val : SEG_BLANK;
      Anodes     <= show ? (AN_OFF ^ sel) : AN_OFF;
      FrameStart <= (presc == '0) && (idx == '0);
    end
  end

endmodule
